// File: rtl/executor_move_pkg.sv
// Shared types for the Tetris tile-motion executor: tiles, points, shapes,
// move commands/results, wall-kick offsets and the angle-step helper.
package executor_move_pkg;

    localparam int unsigned POS_X_W   = 5;  // $clog2(16)+1, signed cell coordinate
    localparam int unsigned POS_Y_W   = 6;  // $clog2(32)+1
    localparam int unsigned MAX_KICKS = 5;

    typedef enum logic [2:0] {eNon, eI, eO, eT, eS, eZ, eJ, eL} tile_type_e;

    typedef struct packed {
        logic [POS_X_W-1:0] x;
        logic [POS_Y_W-1:0] y;
    } point_t;

    typedef struct packed {
        logic [3:0][3:0] shape_m;
    } shape_info_t;

    typedef enum logic [2:0] {eRotCW, eRotCCW, eLeft, eRight, eDown} move_cmd_e;
    typedef enum logic [1:0] {eAccepted, eBlocked, eLanded} move_result_e;
    typedef enum logic [1:0] {eIDLE, eCheck, eWrite, eFail} move_state_e;

    // Horizontal kick order 0,+1,-1,+2,-2 in two's complement at x width.
    localparam logic [POS_X_W-1:0] KICK_DX [MAX_KICKS] = '{5'h00, 5'h01, 5'h1f, 5'h02, 5'h1e};

    function automatic logic [1:0] next_angle(input logic [1:0] angle, input move_cmd_e cmd);
        case (cmd)
            eRotCW:  return angle + 2'd1;
            eRotCCW: return angle - 2'd1;
            default: return angle;
        endcase
    endfunction

endpackage

// File: rtl/executor_move_if.sv
// Command, shape-ROM, matrix-memory and write-back bundle of the move executor.
interface executor_move_if import executor_move_pkg::*; #(
    parameter int width_p  = 16,
    parameter int height_p = 32
);
    localparam int XW = $clog2(width_p) + 1;
    localparam int YW = $clog2(height_p) + 1;

    logic            v_i;
    logic            ready_o;
    move_cmd_e       cmd_i;
    tile_type_e      type_i;
    logic [1:0]      angle_i;
    point_t          pos_i;
    logic [4:0]      rom_read_addr_o;
    shape_info_t     rom_data_i;
    logic [XW-1:0]   mm_addr_r_x_o;
    logic [YW-1:0]   mm_addr_r_y_o;
    logic [3:0][3:0] mm_data_i;
    tile_type_e      type_o;
    logic [1:0]      angle_o;
    point_t          pos_o;
    logic            upd_v_o;
    logic            done_v_o;
    move_result_e    result_o;

    modport slave (
        input  v_i, cmd_i, type_i, angle_i, pos_i, rom_data_i, mm_data_i,
        output ready_o, rom_read_addr_o, mm_addr_r_x_o, mm_addr_r_y_o,
               type_o, angle_o, pos_o, upd_v_o, done_v_o, result_o
    );

    modport master (
        output v_i, cmd_i, type_i, angle_i, pos_i, rom_data_i, mm_data_i,
        input  ready_o, rom_read_addr_o, mm_addr_r_x_o, mm_addr_r_y_o,
               type_o, angle_o, pos_o, upd_v_o, done_v_o, result_o
    );

endinterface

// File: rtl/executor_move_candidate_gen.sv
// Combinational candidate placement for a move command at kick index k.
module executor_move_candidate_gen import executor_move_pkg::*; (
    input  move_cmd_e  cmd,
    input  point_t     pos,
    input  logic [1:0] angle,
    input  logic [2:0] k,
    output point_t     cand_pos,
    output logic [1:0] cand_angle
);

    logic [POS_X_W-1:0] dx;

    always_comb begin
        dx         = (k < 3'(MAX_KICKS)) ? KICK_DX[k] : '0;
        cand_pos   = pos;
        cand_angle = next_angle(angle, cmd);
        case (cmd)
            eRotCW,
            eRotCCW: cand_pos.x = pos.x + dx;
            eLeft:   cand_pos.x = pos.x - POS_X_W'(1);
            eRight:  cand_pos.x = pos.x + POS_X_W'(1);
            eDown:   cand_pos.y = pos.y + POS_Y_W'(1);
            default: cand_pos   = pos;
        endcase
    end

endmodule

// File: rtl/executor_move.sv
// Tile-motion executor: tries one candidate placement per cycle against the
// shape ROM and matrix window, with wall kicks for rotations, then writes back.
module executor_move import executor_move_pkg::*; #(
    parameter int width_p  = 16,
    parameter int height_p = 32,
    parameter int kicks_p  = 5
) (
    input  logic            clk_i,
    input  logic            reset_n_i,
    executor_move_if.slave  bus
);

    localparam int XW = $clog2(width_p) + 1;
    localparam int YW = $clog2(height_p) + 1;
    localparam logic [2:0] LAST_K = 3'(kicks_p - 1);

    move_state_e state_r, state_n;
    move_cmd_e   cmd_r;
    tile_type_e  type_r, type_out_r;
    logic [1:0]  angle_r, angle_out_r, cand_angle;
    point_t      pos_r, pos_out_r, cand_pos;
    logic [2:0]  k_r;

    logic accept, kick, commit, collision, is_rot;
    logic ready, upd, done;
    move_result_e result;

    executor_move_candidate_gen u_cand (
        .cmd        (cmd_r),
        .pos        (pos_r),
        .angle      (angle_r),
        .k          (k_r),
        .cand_pos   (cand_pos),
        .cand_angle (cand_angle)
    );

    assign is_rot    = (cmd_r == eRotCW) || (cmd_r == eRotCCW);
    // An empty slot never fits anywhere, so eNon always reports blocked.
    assign collision = (type_r == eNon) || |(bus.rom_data_i.shape_m & bus.mm_data_i);

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_r     <= eIDLE;
            cmd_r       <= eRotCW;
            type_r      <= eNon;
            angle_r     <= '0;
            pos_r       <= '0;
            k_r         <= '0;
            type_out_r  <= eNon;
            angle_out_r <= '0;
            pos_out_r   <= '0;
        end else begin
            state_r <= state_n;
            if (accept) begin
                cmd_r   <= bus.cmd_i;
                type_r  <= bus.type_i;
                angle_r <= bus.angle_i;
                pos_r   <= bus.pos_i;
                k_r     <= '0;
            end else if (kick) begin
                k_r <= k_r + 3'd1;
            end
            if (commit) begin
                type_out_r  <= type_r;
                angle_out_r <= cand_angle;
                pos_out_r   <= cand_pos;
            end
        end
    end

    always_comb begin
        state_n = state_r;
        accept  = 1'b0;
        kick    = 1'b0;
        commit  = 1'b0;
        ready   = 1'b0;
        upd     = 1'b0;
        done    = 1'b0;
        result  = eAccepted;
        case (state_r)
            eIDLE: begin
                ready = 1'b1;
                if (bus.v_i) begin
                    accept  = 1'b1;
                    state_n = eCheck;
                end
            end
            eCheck: begin
                if (!collision) begin
                    commit  = 1'b1;
                    state_n = eWrite;
                end else if (is_rot && (k_r < LAST_K)) begin
                    kick = 1'b1;
                end else begin
                    state_n = eFail;
                end
            end
            eWrite: begin
                upd     = 1'b1;
                done    = 1'b1;
                state_n = eIDLE;
            end
            eFail: begin
                done    = 1'b1;
                result  = (cmd_r == eDown) ? eLanded : eBlocked;
                state_n = eIDLE;
            end
            default: state_n = eIDLE;
        endcase
    end

    assign bus.ready_o         = ready;
    assign bus.upd_v_o         = upd;
    assign bus.done_v_o        = done;
    assign bus.result_o        = result;
    assign bus.type_o          = type_out_r;
    assign bus.angle_o         = angle_out_r;
    assign bus.pos_o           = pos_out_r;
    assign bus.rom_read_addr_o = {type_r, cand_angle};
    assign bus.mm_addr_r_x_o   = XW'($signed(cand_pos.x));
    assign bus.mm_addr_r_y_o   = YW'($signed(cand_pos.y));

endmodule

// File: tb/tb_executor_move.sv
// Scoreboard bench for executor_move with a small playfield and shape ROM model.
module tb_executor_move;
    import executor_move_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    executor_move_if #(.width_p(16), .height_p(32)) bus();

    executor_move #(.width_p(16), .height_p(32), .kicks_p(5)) dut (
        .clk_i     (clk),
        .reset_n_i (rst_n),
        .bus       (bus)
    );

    typedef struct {
        move_result_e res;
        logic         upd;
        tile_type_e   ty;
        logic [1:0]   ang;
        point_t       pos;
        int           lat;
    } exp_t;

    exp_t exp_q[$];
    int   acc_q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc   = 0;
    logic [15:0] field [32];
    logic block_all;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        n_cmp++;
        if (obs !== want) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, want);
        end
    endtask

    function automatic point_t mkpt(input int x, input int y);
        point_t p;
        p.x = POS_X_W'(x);
        p.y = POS_Y_W'(y);
        return p;
    endfunction

    // Shape ROM: even angles use column 0, odd angles column 2, rows 0-1.
    always_comb begin
        bus.rom_data_i = '0;
        if (bus.rom_read_addr_o[0]) begin
            bus.rom_data_i.shape_m[0][2] = 1'b1;
            bus.rom_data_i.shape_m[1][2] = 1'b1;
        end else begin
            bus.rom_data_i.shape_m[0][0] = 1'b1;
            bus.rom_data_i.shape_m[1][0] = 1'b1;
        end
    end

    // Matrix window; anything outside the 16x32 field reads occupied.
    always_comb begin
        int bx, by, ix, iy;
        bus.mm_data_i = '0;
        bx = $signed(bus.mm_addr_r_x_o);
        by = $signed(bus.mm_addr_r_y_o);
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                ix = bx + c;
                iy = by + r;
                if (block_all || ix < 0 || ix > 15 || iy < 0 || iy > 31)
                    bus.mm_data_i[r][c] = 1'b1;
                else
                    bus.mm_data_i[r][c] = field[iy][ix];
            end
        end
    end

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        exp_t e;
        int   a;
        if (rst_n) begin
            if (bus.done_v_o) begin
                if (exp_q.size() == 0 || acc_q.size() == 0) begin
                    chk("spurious_done", bus.done_v_o, 1'b0);
                end else begin
                    e = exp_q.pop_front();
                    a = acc_q.pop_front();
                    chk("result",  bus.result_o, e.res);
                    chk("upd",     bus.upd_v_o, e.upd);
                    chk("latency", cyc - a + 1, e.lat);
                    chk("type_o",  bus.type_o, e.ty);
                    chk("angle_o", bus.angle_o, e.ang);
                    chk("pos_o",   bus.pos_o, e.pos);
                end
            end else if (bus.upd_v_o) begin
                chk("upd_wo_done", bus.upd_v_o, 1'b0);
            end
            if (bus.v_i && bus.ready_o) acc_q.push_back(cyc + 1);
        end
    end

    task automatic expect_done(input move_result_e r, input logic u, input tile_type_e t,
                               input logic [1:0] a, input point_t p, input int lat);
        exp_t e;
        e.res = r; e.upd = u; e.ty = t; e.ang = a; e.pos = p; e.lat = lat;
        exp_q.push_back(e);
    endtask

    task automatic issue(input move_cmd_e c, input tile_type_e t, input logic [1:0] a, input point_t p);
        @(posedge clk); #1;
        bus.cmd_i = c; bus.type_i = t; bus.angle_i = a; bus.pos_i = p; bus.v_i = 1'b1;
        @(posedge clk); #1;
        bus.v_i = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (exp_q.size() != 0 && n < 40) begin
            @(posedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            chk({tag, "_timeout"}, exp_q.size(), 0);
            exp_q.delete();
            acc_q.delete();
        end
    endtask

    task automatic clear_field();
        for (int y = 0; y < 32; y++) field[y] = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.v_i = 1'b0; bus.cmd_i = eRotCW; bus.type_i = eNon; bus.angle_i = '0; bus.pos_i = '0;
        block_all = 1'b0;
        clear_field();

        #11;
        chk("rst_ready",  bus.ready_o, 1'b1);
        chk("rst_upd",    bus.upd_v_o, 1'b0);
        chk("rst_done",   bus.done_v_o, 1'b0);
        chk("rst_type",   bus.type_o, eNon);
        chk("rst_angle",  bus.angle_o, 2'd0);
        chk("rst_pos",    bus.pos_o, mkpt(0, 0));
        chk("rst_result", bus.result_o, eAccepted);
        #1 rst_n = 1'b1;

        // Free rotation.
        expect_done(eAccepted, 1'b1, eT, 2'd1, mkpt(6, 0), 2);
        issue(eRotCW, eT, 2'd0, mkpt(6, 0));
        wait_done("rot_free");

        // CCW with dx=0 blocked, dx=+1 free.
        field[0][8] = 1'b1;
        expect_done(eAccepted, 1'b1, eT, 2'd3, mkpt(7, 0), 3);
        issue(eRotCCW, eT, 2'd0, mkpt(6, 0));
        wait_done("rot_kick1");

        // CW needing dx=-1 (third candidate).
        field[0][9] = 1'b1;
        expect_done(eAccepted, 1'b1, eT, 2'd1, mkpt(5, 0), 4);
        issue(eRotCW, eT, 2'd0, mkpt(6, 0));
        wait_done("rot_kick2");

        // CW needing dx=-2 (last candidate).
        field[0][7] = 1'b1; field[0][10] = 1'b1;
        expect_done(eAccepted, 1'b1, eT, 2'd1, mkpt(4, 0), 6);
        issue(eRotCW, eT, 2'd0, mkpt(6, 0));
        wait_done("rot_kick4");

        // Every candidate blocked: outputs hold.
        block_all = 1'b1;
        expect_done(eBlocked, 1'b0, eT, 2'd1, mkpt(4, 0), 6);
        issue(eRotCW, eT, 2'd0, mkpt(6, 0));
        wait_done("rot_blocked");
        block_all = 1'b0;
        clear_field();

        // Drop onto the floor row.
        field[30] = 16'hffff;
        expect_done(eLanded, 1'b0, eT, 2'd1, mkpt(4, 0), 2);
        issue(eDown, eT, 2'd0, mkpt(4, 28));
        wait_done("down_land");

        expect_done(eAccepted, 1'b1, eT, 2'd0, mkpt(4, 21), 2);
        issue(eDown, eT, 2'd0, mkpt(4, 20));
        wait_done("down_free");

        // Left wall at x=0.
        expect_done(eBlocked, 1'b0, eT, 2'd0, mkpt(4, 21), 2);
        issue(eLeft, eO, 2'd0, mkpt(0, 5));
        wait_done("left_wall");

        expect_done(eAccepted, 1'b1, eO, 2'd0, mkpt(4, 5), 2);
        issue(eLeft, eO, 2'd0, mkpt(5, 5));
        wait_done("left_free");

        // Asynchronous reset while checking kick index 2.
        block_all = 1'b1;
        issue(eRotCW, eT, 2'd0, mkpt(6, 0));
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_ready", bus.ready_o, 1'b1);
        chk("mid_rst_done",  bus.done_v_o, 1'b0);
        chk("mid_rst_upd",   bus.upd_v_o, 1'b0);
        chk("mid_rst_type",  bus.type_o, eNon);
        #1 rst_n = 1'b1;
        exp_q.delete();
        acc_q.delete();
        block_all = 1'b0;
        repeat (3) @(posedge clk);

        // Back-to-back eRight with v_i held high.
        expect_done(eAccepted, 1'b1, eS, 2'd0, mkpt(4, 10), 2);
        expect_done(eAccepted, 1'b1, eS, 2'd0, mkpt(5, 10), 2);
        @(posedge clk); #1;
        bus.cmd_i = eRight; bus.type_i = eS; bus.angle_i = 2'd0; bus.pos_i = mkpt(3, 10); bus.v_i = 1'b1;
        @(posedge clk); #1;
        bus.pos_i = mkpt(4, 10);
        @(posedge clk); #1;
        chk("b2b_busy", bus.ready_o, 1'b0);
        @(posedge clk); #1;
        chk("b2b_ready", bus.ready_o, 1'b1);
        @(posedge clk); #1;
        bus.v_i = 1'b0;
        wait_done("b2b");

        // Empty tile type always collides.
        expect_done(eBlocked, 1'b0, eS, 2'd0, mkpt(5, 10), 6);
        issue(eRotCW, eNon, 2'd0, mkpt(8, 8));
        wait_done("type_non");

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/executor_move.md
Name: executor_move

Overview:
- Generalised tile-motion executor for the Tetris datapath; the successor to the single-purpose rotate executor.
- Takes one command per handshake: rotate CW, rotate CCW, shift left, shift right or soft drop.
- For each candidate placement it looks up the shape ROM and the 4x4 matrix-memory window, checks for collision, and tries up to kicks_p horizontal wall-kick offsets for rotations.
- Reports accepted, blocked or landed, and writes the new type/angle/position back to the current-state memory.

Parameters:
width_p, 16, playfield width in cells
height_p, 32, playfield height in cells
kicks_p, 5, rotation candidates tried (1..5); offset order dx = 0,+1,-1,+2,-2, truncated to kicks_p

Ports:
clk_i  in  1  clock
reset_n_i  in  1  reset, asynchronous, active-low
v_i  in  1  command valid
ready_o  out  1  ready for a command; a command is accepted when v_i & ready_o
cmd_i  in  move_cmd_e (3)  eRotCW, eRotCCW, eLeft, eRight, eDown
type_i  in  tile_type_e  current tile type
angle_i  in  2  current angle
pos_i  in  point_t  current top-left position of the 4x4 box
rom_read_addr_o  out  5  {type, candidate angle}
rom_data_i  in  shape_info_t  shape for rom_read_addr_o, combinational
mm_addr_r_x_o  out  $clog2(width_p)+1  candidate x (signed)
mm_addr_r_y_o  out  $clog2(height_p)+1  candidate y (signed)
mm_data_i  in  [3:0][3:0]  occupancy window, combinational; out-of-field cells read 1
type_o  out  tile_type_e  type to write back
angle_o  out  2  angle to write back
pos_o  out  point_t  position to write back
upd_v_o  out  1  write-back strobe for the state memory
done_v_o  out  1  command complete, one-cycle pulse
result_o  out  move_result_e (2)  eAccepted, eBlocked, eLanded; valid while done_v_o is high

Behaviour:
- Reset is asynchronous and active-low. While reset_n_i is low:
  - state = eIDLE, so ready_o=1 and upd_v_o=done_v_o=0.
  - Latched type = eNon; angle, pos and kick index are 0; result_o = eAccepted.
- A reset mid-command abandons the command with no write-back.
- FSM states: eIDLE, eCheck, eWrite, eFail.
- eIDLE:
  - On v_i, latch cmd, type, angle and pos, clear the kick index k, and go to eCheck.
  - v_i is ignored in every other state, because ready_o=0 there.
- Candidate formation (combinational from the latched values and k):
  - eRotCW: angle+1 (3 wraps to 0), x + dx[k]
  - eRotCCW: angle-1 (0 wraps to 3), x + dx[k]
  - eLeft: x-1
  - eRight: x+1
  - eDown: y+1
- Arithmetic is two's complement at the point_t field width. Negative and over-range coordinates are legal addresses; walls come from the memory returning 1s.
- collision = |(rom_data_i.shape_m & mm_data_i), an OR-reduction.
- eCheck, one candidate per cycle:
  - No collision: latch the candidate into the output registers and go to eWrite.
  - Collision on a rotation with k < kicks_p-1: k++ and stay in eCheck.
  - Otherwise go to eFail.
  - A latched type of eNon forces collision.
- eWrite, one cycle:
  - upd_v_o=1, done_v_o=1, result_o=eAccepted.
  - type_o/angle_o/pos_o hold the accepted candidate.
  - Next state eIDLE.
- eFail, one cycle:
  - done_v_o=1 and upd_v_o=0.
  - result_o = eLanded if cmd was eDown, else eBlocked.
  - Next state eIDLE.
  - type_o/angle_o/pos_o keep their previous values.
- Latency, with acceptance at edge 0:
  - Success on candidate k: eWrite occupies cycle k+2.
  - Move/drop failure: eFail in cycle 2.
  - Rotation failure: eFail in cycle kicks_p+1.
  - Back-to-back: ready_o returns in the cycle after eWrite/eFail, so a new command can be accepted then.
- ROM and memory outputs are don't-care outside eCheck but must be driven from registers/decoded state (no X).

Decomposition:
- Add to the tetris package:
  - move_cmd_e and move_result_e
  - the kick offset constant array
  - a function next_angle(angle, cmd)
- The existing tile_type_e, point_t and shape_info_t stay there.
- One natural sub-module: move_candidate_gen, which is purely combinational and maps (cmd, pos, angle, k) to candidate pos/angle.

Test Plan:
- Free field, tile eT at pos (6,0), angle 0, eRotCW -> upd_v_o in cycle 2; angle_o=1, pos_o=(6,0), result eAccepted.
- Angle 0, eRotCCW with the memory blocking dx=0 but free at dx=+1 -> eWrite in cycle 3; angle_o=3, pos_o.x=7.
- eRotCW with all 5 candidates colliding -> done_v_o in cycle 6, result eBlocked, upd_v_o never high, outputs unchanged.
- eDown at y=28 with floor cells =1 -> eFail in cycle 2, result eLanded. eLeft at x=0 with wall column set -> eBlocked.
- Pulse reset_n_i low asynchronously while in eCheck (kick index 2) -> ready_o=1 immediately; no upd_v_o/done_v_o; next command behaves normally.
- Back-to-back eRight, eRight with v_i held high, from x=3 -> two eWrite pulses with pos_o.x=4 then 5; second accept in the cycle after the first eWrite.
